// File: rtl/image_loader.sv
// Byte-stream frame loader: label byte + NUM_PIXELS pixels -> fixed-point image bank, 1 cycle from last pixel to image_valid.
// in_ready drops while a complete frame waits for image_ack; bad-label frames are consumed and discarded.
module image_loader #(
    parameter int NUM_PIXELS  = 784,
    parameter int DATA_W      = 32,
    parameter int FRAC_BITS   = 16,
    parameter int NUM_CLASSES = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [DATA_W*NUM_PIXELS-1:0] image_out,
    output logic [7:0]                   label_out,
    output logic                         image_valid,
    input  logic                         image_ack,
    output logic                         label_err,
    output logic [15:0]                  frame_count
);

    localparam int                CNT_W    = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NUM_PIXELS - 1);
    localparam logic [8:0]        NUM_CLS  = 9'(NUM_CLASSES);

    typedef enum logic [1:0] {LABEL, PIXELS, DROP, FULL} state_t;

    state_t                               state_q;
    logic [CNT_W-1:0]                     cnt_q;
    logic [CNT_W-1:0]                     cnt_d;
    logic                                 in_ready_q;
    logic                                 image_valid_q;
    logic                                 label_err_q;
    logic [7:0]                           label_q;
    logic [15:0]                          frame_count_q;
    logic [NUM_PIXELS-1:0][DATA_W-1:0]    img_q;

    logic                                 accept;
    logic                                 last;
    logic [DATA_W-1:0]                    pix_word;

    assign accept   = in_valid && in_ready_q;
    assign last     = (cnt_q == LAST_IDX);
    assign cnt_d    = last ? '0 : cnt_q + CNT_W'(1);
    // p/256 in unsigned fixed point: the byte lands just above the low FRAC_BITS-8 zero bits.
    assign pix_word = DATA_W'(in_data) << (FRAC_BITS - 8);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= LABEL;
            cnt_q         <= '0;
            in_ready_q    <= 1'b0;
            image_valid_q <= 1'b0;
            label_err_q   <= 1'b0;
            label_q       <= '0;
            frame_count_q <= '0;
            img_q         <= '0;
        end else begin
            label_err_q <= 1'b0;
            case (state_q)
                LABEL: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        cnt_q <= '0;
                        if ({1'b0, in_data} < NUM_CLS) begin
                            label_q <= in_data;
                            state_q <= PIXELS;
                        end else begin
                            label_err_q <= 1'b1;
                            state_q     <= DROP;
                        end
                    end
                end
                PIXELS: begin
                    if (accept) begin
                        img_q[cnt_q] <= pix_word;
                        cnt_q        <= cnt_d;
                        if (last) begin
                            image_valid_q <= 1'b1;
                            in_ready_q    <= 1'b0;
                            if (frame_count_q != 16'hFFFF)
                                frame_count_q <= frame_count_q + 16'd1;
                            state_q <= FULL;
                        end
                    end
                end
                DROP: begin
                    if (accept) begin
                        cnt_q <= cnt_d;
                        if (last)
                            state_q <= LABEL;
                    end
                end
                FULL: begin
                    if (image_ack) begin
                        image_valid_q <= 1'b0;
                        in_ready_q    <= 1'b1;
                        state_q       <= LABEL;
                    end
                end
                default: state_q <= LABEL;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign image_valid = image_valid_q;
    assign label_err   = label_err_q;
    assign label_out   = label_q;
    assign frame_count = frame_count_q;
    assign image_out   = img_q;

endmodule

// File: tb/tb_image_loader.sv
// Directed + randomized frames against a frame-level reference model of the loader.
module tb_image_loader;

    localparam int NUM_PIXELS  = 784;
    localparam int DATA_W      = 32;
    localparam int FRAC_BITS   = 16;
    localparam int NUM_CLASSES = 10;
    localparam int SCALE       = 1 << (FRAC_BITS - 8);

    logic                         clk;
    logic                         rst;
    logic [7:0]                   in_data;
    logic                         in_valid;
    logic                         in_ready;
    logic [DATA_W*NUM_PIXELS-1:0] image_out;
    logic [7:0]                   label_out;
    logic                         image_valid;
    logic                         image_ack;
    logic                         label_err;
    logic [15:0]                  frame_count;

    image_loader #(
        .NUM_PIXELS (NUM_PIXELS),
        .DATA_W     (DATA_W),
        .FRAC_BITS  (FRAC_BITS),
        .NUM_CLASSES(NUM_CLASSES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .image_out  (image_out),
        .label_out  (label_out),
        .image_valid(image_valid),
        .image_ack  (image_ack),
        .label_err  (label_err),
        .frame_count(frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          passes = 0;
    int unsigned exp_img [NUM_PIXELS];
    logic [7:0]  exp_label;
    int unsigned exp_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_image(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < NUM_PIXELS; i++)
            if (image_out[i*DATA_W +: DATA_W] !== exp_img[i]) bad++;
        check(tag, 32'(bad), 32'd0);
    endtask

    function automatic int gap_for(input int mode);
        if (mode == 2 && $urandom_range(0, 3) == 0) return int'($urandom_range(1, 3));
        return 0;
    endfunction

    // Returns on the falling edge just after the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit spur_ack);
        int w;
        for (int g = 0; g < gap; g++) begin
            in_valid  = 1'b0;
            image_ack = spur_ack ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        image_ack = 1'b0;
        in_valid  = 1'b1;
        in_data   = b;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // mode 0: pixel k = k mod 256, 1: all 8'hAA, 2: random data with bubbles and stray acks.
    task automatic run_frame(input logic [7:0] lbl, input int mode, input int npix);
        bit         good;
        bit         early;
        logic [7:0] p;
        good = (lbl < NUM_CLASSES);
        send_byte(lbl, gap_for(mode), mode == 2);
        check("label_err_pulse", 32'(label_err), 32'(!good));
        early = 1'b0;
        for (int k = 0; k < npix; k++) begin
            if (k == NUM_PIXELS - 1 && image_valid) early = 1'b1;
            p = (mode == 0) ? 8'(k % 256) : (mode == 1) ? 8'hAA : 8'($urandom_range(0, 255));
            send_byte(p, gap_for(mode), mode == 2);
            if (k == 0) check("label_err_clear", 32'(label_err), 32'd0);
            if (good) exp_img[k] = int'(p) * SCALE;
            if (k < NUM_PIXELS - 1 && image_valid) early = 1'b1;
        end
        check("no_early_valid", 32'(early), 32'd0);
        if (npix == NUM_PIXELS) begin
            if (good) begin
                exp_label = lbl;
                if (exp_count != 32'hFFFF) exp_count++;
            end
            check("image_valid", 32'(image_valid), 32'(good));
            check("in_ready_after_frame", 32'(in_ready), 32'(!good));
            check("label_out", 32'(label_out), 32'(exp_label));
            check("frame_count", 32'(frame_count), exp_count);
            check_image("image_words");
        end
    endtask

    task automatic do_ack();
        image_ack = 1'b1;
        @(negedge clk);
        image_ack = 1'b0;
        check("ack_valid_low", 32'(image_valid), 32'd0);
        check("ack_ready_high", 32'(in_ready), 32'd1);
        check("ack_count_hold", 32'(frame_count), exp_count);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_PIXELS; i++) exp_img[i] = 0;
        exp_label = 8'd0;
        exp_count = 0;
    endtask

    initial begin
        logic [7:0] lbl;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        image_ack = 1'b0;
        model_reset();

        // Reset and release
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_image_valid", 32'(image_valid), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_label_out", 32'(label_out), 32'd0);
        check("rst_label_err", 32'(label_err), 32'd0);
        check_image("rst_image");
        rst = 1'b1;
        #1 check("release_ready_before_edge", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("release_ready_after_edge", 32'(in_ready), 32'd1);

        // Gap-free frame, label 7, pixel k = k mod 256
        run_frame(8'd7, 0, NUM_PIXELS);
        check("word255", image_out[255*DATA_W +: DATA_W], 32'h0000FF00);
        check("word128", image_out[128*DATA_W +: DATA_W], 32'h00008000);
        check("word0", image_out[0 +: DATA_W], 32'h0);

        // Backpressure while FULL
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("bp_ready_low", 32'(in_ready), 32'd0);
        check("bp_valid_held", 32'(image_valid), 32'd1);
        check("bp_label_held", 32'(label_out), 32'd7);
        check("bp_count_held", 32'(frame_count), exp_count);
        check_image("bp_image_held");
        do_ack();

        // Bad label: whole frame consumed, previous image retained
        run_frame(8'd12, 1, NUM_PIXELS);

        // Label 3 with bubbles and stray acks, then random-label frames
        run_frame(8'd3, 2, NUM_PIXELS);
        do_ack();
        for (int f = 0; f < 4; f++) begin
            lbl = 8'($urandom_range(0, 14));
            run_frame(lbl, 2, NUM_PIXELS);
            if (lbl < NUM_CLASSES) do_ack();
        end
        run_frame(8'd255, 2, NUM_PIXELS);

        // Reset in the middle of a frame
        run_frame(8'd5, 0, 401);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_valid", 32'(image_valid), 32'd0);
        check("mid_rst_label_out", 32'(label_out), 32'd0);
        check("mid_rst_count", 32'(frame_count), 32'd0);
        check("mid_rst_label_err", 32'(label_err), 32'd0);
        check_image("mid_rst_image");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("re_release_ready", 32'(in_ready), 32'd1);
        run_frame(8'd2, 2, NUM_PIXELS);
        check("post_rst_count_one", 32'(frame_count), 32'd1);
        do_ack();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/image_loader.md
Name: image_loader

Overview:
- Upstream stage of the network top.
- Accepts a byte stream with a valid/ready handshake. Each frame is one label byte followed by NUM_PIXELS pixel bytes.
- Converts each pixel to DATA_W-bit fixed point and assembles the full image in a register bank.
- Presents image plus label to the control unit's image/label inputs under a valid/ack handshake. Frames with out-of-range labels are discarded.

Parameters:
- NUM_PIXELS, 784: pixels per frame.
- DATA_W, 32: width of one fixed-point pixel word.
- FRAC_BITS, 16: fractional bits of the output format. Legal range is 8 to DATA_W-8.
- NUM_CLASSES, 10: labels 0..NUM_CLASSES-1 are valid.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_data  in  8  stream byte (label or pixel).
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle.
- image_out  out  DATA_W*NUM_PIXELS  assembled image. Pixel i is at bits [i*DATA_W +: DATA_W]; pixel 0 is the first pixel byte of the frame.
- label_out  out  8  label of the presented frame.
- image_valid  out  1  image_out/label_out hold a complete frame.
- image_ack  in  1  consumer has taken the frame.
- label_err  out  1  one-cycle pulse: a label >= NUM_CLASSES was received.
- frame_count  out  16  count of frames presented; saturates at 16'hFFFF.

Behaviour:
- Transfer rule: a byte is accepted on a rising edge where in_valid && in_ready.
- All outputs are registered.
- Reset (rst=0, asynchronous), all take effect immediately:
  - state=LABEL, in_ready=0, image_valid=0, label_err=0.
  - label_out=0, frame_count=0, pixel counter=0, every image_out word=0.
- On the first clock edge after rst goes high, in_ready becomes 1.
- State LABEL (in_ready=1):
  - Accepted byte b with b < NUM_CLASSES: label_out<=b, pixel counter<=0, go to PIXELS.
  - Otherwise: label_err<=1 for exactly one cycle, pixel counter<=0, go to DROP. label_out keeps its old value.
- State PIXELS (in_ready=1):
  - Accepted pixel p at counter i: word i <= p << (FRAC_BITS-8), zero-extended, i.e. p/256 in unsigned fixed point.
  - Counter increments by 1.
  - On acceptance of pixel NUM_PIXELS-1, at that same edge: image_valid<=1, in_ready<=0, frame_count increments unless already 16'hFFFF, go to FULL.
  - Words are written in place as they arrive. image_out is defined only while image_valid=1.
- State DROP (in_ready=1):
  - Consumes NUM_PIXELS bytes without writing any word; image_out keeps the prior frame.
  - After the last byte: return to LABEL, in_ready stays 1, image_valid stays 0, frame_count unchanged.
- State FULL (in_ready=0, image_valid=1):
  - image_out and label_out are held stable. in_valid is ignored.
  - Edge with image_ack=1: image_valid<=0, in_ready<=1, go to LABEL.
  - Minimum frame turnaround is NUM_PIXELS+2 cycles: 1 label + NUM_PIXELS pixels + 1 ack cycle.
- image_ack while image_valid=0 is ignored and has no side effect.
- Idle cycles (in_valid=0) in any state hold all state. Bubbles between bytes are legal anywhere in a frame.
- Reset mid-frame or in FULL: immediate return to reset values. The partial frame is lost, frame_count=0.
- Pixel counter width is clog2(NUM_PIXELS). It never exceeds NUM_PIXELS-1.

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles, then release -> in_ready=0 during reset, in_ready=1 one edge after release, image_valid=0, frame_count=0.
- Full frame, defaults: label 8'd7, then pixel k = k mod 256 with no bubbles -> image_valid=1 exactly one cycle after the 784th accept, label_out=7. Word 255 = 32'h0000FF00, word 128 = 32'h00008000, word 0 = 0. in_ready=0 and frame_count=1.
- Backpressure: keep in_valid=1 with new data while FULL for 20 cycles -> no bytes taken, image_out unchanged. Assert image_ack -> next edge image_valid=0, in_ready=1; the following byte is taken as a label.
- Bad label: label 8'd12 followed by 784 bytes of 8'hAA -> label_err high for one cycle, image_valid never asserts, image_out equals previous frame, frame_count unchanged. The next label 8'd3 is accepted normally.
- Bubbles and spurious ack: random in_valid gaps throughout a frame, plus image_ack pulses while not FULL -> same image_out as the gap-free run, no early valid.
- Mid-frame reset: drop rst after pixel 400 -> all outputs return to reset values immediately. A subsequent clean frame loads correctly with frame_count=1.
